// File: rtl/ahb_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ahb_decoder_pkg
// Shared types and constants for the AHB slave decoder.
//   SLAVE1_BASE / SLAVE2_BASE : HADDR[31:16] values for the two mapped slaves
//   dphase_t                  : data-phase owner (NONE, S1, S2, DEF)
//   err_state_t               : default-slave error response sequencer states
//   decode_region()           : maps HADDR[31:16] to S1, S2 or DEF
// ---------------------------------------------------------------------------
package ahb_decoder_pkg;

    localparam logic [15:0] SLAVE1_BASE = 16'h0000;
    localparam logic [15:0] SLAVE2_BASE = 16'h0001;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2,
        DEF  = 2'd3
    } dphase_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } err_state_t;

    function automatic dphase_t decode_region(input logic [15:0] addr_hi);
        dphase_t r;
        if (addr_hi == SLAVE1_BASE) begin
            r = S1;
        end else if (addr_hi == SLAVE2_BASE) begin
            r = S2;
        end else begin
            r = DEF;
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb_slave_decoder_if.sv
// ---------------------------------------------------------------------------
// ahb_slave_decoder_if
// Bus-side signals of the AHB slave decoder.
//   HADDR, HTRANS          : address phase from the master
//   HREADY_MUX, HRESP_MUX  : response returned by the slave multiplexer
//   HSEL_1, HSEL_2         : slave selects (combinational decode)
//   muxSelect              : data-phase multiplexer select (1 = slave 2)
//   HREADY, HRESP          : final bus response
//   err_count              : saturating count of completed ERROR responses
// Modport slave is used by the decoder, modport master by the driving side.
// ---------------------------------------------------------------------------
interface ahb_slave_decoder_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HREADY_MUX;
    logic        HRESP_MUX;
    logic        HSEL_1;
    logic        HSEL_2;
    logic        muxSelect;
    logic        HREADY;
    logic        HRESP;
    logic [7:0]  err_count;

    modport slave (
        input  HADDR, HTRANS, HREADY_MUX, HRESP_MUX,
        output HSEL_1, HSEL_2, muxSelect, HREADY, HRESP, err_count
    );

    modport master (
        output HADDR, HTRANS, HREADY_MUX, HRESP_MUX,
        input  HSEL_1, HSEL_2, muxSelect, HREADY, HRESP, err_count
    );
endinterface

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
// Two-cycle AHB ERROR response for unmapped addresses plus a saturating
// error counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : an unmapped transfer is accepted this cycle
//   hready     : 0 in ERR1, 1 otherwise
//   hresp      : 1 in ERR1 and ERR2
//   err_count  : completed ERROR responses, saturates at 8'hFF
// ---------------------------------------------------------------------------
module ahb_default_slave
    import ahb_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       hready,
    output logic       hresp,
    output logic [7:0] err_count
);

    err_state_t state_q, state_d;
    logic [7:0] count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= 8'h00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: if (start) state_d = ERR1;
            ERR1: state_d = ERR2;
            ERR2: begin
                if (count_q != 8'hFF) count_d = count_q + 8'd1;
                // ERR2 drives HREADY=1, so the next transfer can be accepted
                // here; a back-to-back unmapped one goes straight to ERR1.
                state_d = start ? ERR1 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hready    = (state_q != ERR1);
    assign hresp     = (state_q == ERR1) || (state_q == ERR2);
    assign err_count = count_q;

endmodule

// File: rtl/ahb_slave_decoder.sv
// ---------------------------------------------------------------------------
// ahb_slave_decoder
// Address decoder and response multiplexer for two AHB slaves.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   bus           : ahb_slave_decoder_if.slave (address phase in, selects
//                   and final HREADY/HRESP/err_count out)
// Macro DEFAULT_SLAVE_EN: when defined, unmapped transfers get a two-cycle
// ERROR response from ahb_default_slave; when undefined they complete as a
// zero-wait OKAY and err_count is 0.
// ---------------------------------------------------------------------------
module ahb_slave_decoder
    import ahb_decoder_pkg::*;
(
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_slave_decoder_if.slave   bus
);

    dphase_t dphase_q, dphase_d;
    dphase_t region;
    logic    accept;
    logic    hready_int, hresp_int;
    logic    err_hready, err_hresp;
    logic [7:0] err_cnt;

    assign region     = decode_region(bus.HADDR[31:16]);
    assign bus.HSEL_1 = (region == S1);
    assign bus.HSEL_2 = (region == S2);
    assign accept     = hready_int & bus.HTRANS[1];

    always_comb begin
        dphase_d = dphase_q;
        // Only sample the address phase when the bus is ready; during wait
        // states the current data phase owner is held.
        if (hready_int) begin
            if (accept) begin
`ifdef DEFAULT_SLAVE_EN
                dphase_d = region;
`else
                dphase_d = (region == DEF) ? NONE : region;
`endif
            end else begin
                dphase_d = NONE;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dphase_q <= NONE;
        end else begin
            dphase_q <= dphase_d;
        end
    end

`ifdef DEFAULT_SLAVE_EN
    logic err_start;
    assign err_start = accept & (region == DEF);

    ahb_default_slave u_default_slave (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .start     (err_start),
        .hready    (err_hready),
        .hresp     (err_hresp),
        .err_count (err_cnt)
    );
`else
    // DEF is never loaded in this build; constants keep the mux complete.
    assign err_hready = 1'b1;
    assign err_hresp  = 1'b0;
    assign err_cnt    = 8'h00;
`endif

    always_comb begin
        hready_int = 1'b1;
        hresp_int  = 1'b0;
        case (dphase_q)
            S1, S2: begin
                hready_int = bus.HREADY_MUX;
                hresp_int  = bus.HRESP_MUX;
            end
            DEF: begin
                hready_int = err_hready;
                hresp_int  = err_hresp;
            end
            default: begin
                hready_int = 1'b1;
                hresp_int  = 1'b0;
            end
        endcase
    end

    assign bus.muxSelect = (dphase_q == S2);
    assign bus.HREADY    = hready_int;
    assign bus.HRESP     = hresp_int;
    assign bus.err_count = err_cnt;

endmodule

// File: tb/tb_ahb_slave_decoder.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_decoder
// Directed bench for ahb_slave_decoder. Inputs change 1 ns after the rising
// edge and outputs are sampled 2 ns later, well away from the next edge.
// Unmapped-address expectations depend on DEFAULT_SLAVE_EN.
// ---------------------------------------------------------------------------
module tb_ahb_slave_decoder;
    import ahb_decoder_pkg::*;

    logic HCLK;
    logic HRESETn;

    ahb_slave_decoder_if bus ();

    ahb_slave_decoder dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[%0t] FAIL %s: got %0h, expected %0h", $time, tag, act, exp);
        end else begin
            $display("[%0t] ok   %s: %0h", $time, tag, act);
        end
    endtask

    // Advance to the next cycle: edge, then new inputs, then sample point.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] trans, input logic [31:0] addr,
                         input logic rdy, input logic resp);
        bus.HTRANS     = trans;
        bus.HADDR      = addr;
        bus.HREADY_MUX = rdy;
        bus.HRESP_MUX  = resp;
        #2;
    endtask

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    int exp_cnt;

    initial begin
        // ---------------- reset ----------------
        HRESETn = 1'b0;
        bus.HTRANS = T_NONSEQ;
        bus.HADDR = 32'h0000_0004;
        bus.HREADY_MUX = 1'b0;
        bus.HRESP_MUX = 1'b1;
        repeat (3) @(posedge HCLK);
        #3;
        check("rst_hready",    32'(bus.HREADY), 1);
        check("rst_hresp",     32'(bus.HRESP), 0);
        check("rst_muxsel",    32'(bus.muxSelect), 0);
        check("rst_errcnt",    32'(bus.err_count), 0);
        check("rst_hsel1",     32'(bus.HSEL_1), 1);
        HRESETn = 1'b1;

        // ---------------- slave 2 select ----------------
        step(); drive(T_NONSEQ, 32'h0001_0010, 1'b1, 1'b0);
        check("s2_hsel2",      32'(bus.HSEL_2), 1);
        check("s2_hsel1",      32'(bus.HSEL_1), 0);
        check("s2_addr_muxsel",32'(bus.muxSelect), 0);
        step(); drive(T_IDLE, 32'h0000_0000, 1'b1, 1'b1);
        check("s2_dp_muxsel",  32'(bus.muxSelect), 1);
        check("s2_dp_hresp",   32'(bus.HRESP), 1);
        step(); drive(T_IDLE, 32'h0000_0000, 1'b1, 1'b1);
        check("s2_after_muxsel", 32'(bus.muxSelect), 0);
        check("s2_after_hresp",  32'(bus.HRESP), 0);

        // ---------------- slave 1 with wait states ----------------
        step(); drive(T_NONSEQ, 32'h0000_0100, 1'b1, 1'b0);
        step(); drive(T_NONSEQ, 32'h0001_0000, 1'b0, 1'b0);
        check("s1w1_hready",   32'(bus.HREADY), 0);
        check("s1w1_muxsel",   32'(bus.muxSelect), 0);
        step(); drive(T_NONSEQ, 32'h0001_0000, 1'b0, 1'b0);
        check("s1w2_hready",   32'(bus.HREADY), 0);
        check("s1w2_muxsel",   32'(bus.muxSelect), 0);
        step(); drive(T_NONSEQ, 32'h0001_0000, 1'b1, 1'b0);
        check("s1w3_hready",   32'(bus.HREADY), 1);
        check("s1w3_muxsel",   32'(bus.muxSelect), 0);
        step(); drive(T_IDLE, 32'h0000_0000, 1'b1, 1'b0);
        check("s1_pending_muxsel", 32'(bus.muxSelect), 1);

        // ---------------- unmapped address ----------------
        step(); drive(T_NONSEQ, 32'h0002_0000, 1'b1, 1'b0);
        check("um_hsel1",      32'(bus.HSEL_1), 0);
        check("um_hsel2",      32'(bus.HSEL_2), 0);
        step(); drive(T_IDLE, 32'h0000_0000, 1'b0, 1'b0);
`ifdef DEFAULT_SLAVE_EN
        check("um_err1_hready", 32'(bus.HREADY), 0);
        check("um_err1_hresp",  32'(bus.HRESP), 1);
        step(); drive(T_IDLE, 32'h0000_0000, 1'b0, 1'b0);
        check("um_err2_hready", 32'(bus.HREADY), 1);
        check("um_err2_hresp",  32'(bus.HRESP), 1);
        step(); drive(T_IDLE, 32'h0000_0000, 1'b0, 1'b0);
        check("um_done_hresp",  32'(bus.HRESP), 0);
        check("um_errcnt",      32'(bus.err_count), 1);

        // ---------------- saturation ----------------
        exp_cnt = 1;
        drive(T_NONSEQ, 32'h0002_0000, 1'b1, 1'b0);
        step(); #2;  // now in ERR1
        for (int i = 0; i < 300; i++) begin
            step(); #2;  // ERR2, next unmapped transfer accepted
            if (i == 299) begin
                bus.HTRANS = T_IDLE;
                #1;
            end
            step(); #2;  // ERR1 again (or idle after the last one)
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            if (i == 0) begin
                check("b2b_err1_hready", 32'(bus.HREADY), 0);
                check("b2b_err1_hresp",  32'(bus.HRESP), 1);
            end
            if (i == 100) check("sat_mid_errcnt", 32'(bus.err_count), 32'(exp_cnt));
        end
        check("sat_errcnt",    32'(bus.err_count), 255);
        repeat (3) step();
        check("sat_hold_errcnt", 32'(bus.err_count), 255);
`else
        check("um_ok_hready",  32'(bus.HREADY), 1);
        check("um_ok_hresp",   32'(bus.HRESP), 0);
        step(); drive(T_IDLE, 32'h0000_0000, 1'b0, 1'b0);
        check("um_errcnt",     32'(bus.err_count), 0);
`endif

        // ---------------- idle transfer ----------------
        step(); drive(T_IDLE, 32'h0000_0000, 1'b0, 1'b1);
        step(); drive(T_IDLE, 32'h0000_0000, 1'b0, 1'b1);
        check("idle_hready",   32'(bus.HREADY), 1);
        check("idle_hresp",    32'(bus.HRESP), 0);
        check("idle_muxsel",   32'(bus.muxSelect), 0);

        // ---------------- reset during a wait state ----------------
        step(); drive(T_NONSEQ, 32'h0001_0020, 1'b1, 1'b0);
        step(); drive(T_IDLE, 32'h0000_0000, 1'b0, 1'b1);
        check("mid_wait_hready", 32'(bus.HREADY), 0);
        HRESETn = 1'b0;
        #1;
        check("mid_rst_hready", 32'(bus.HREADY), 1);
        check("mid_rst_muxsel", 32'(bus.muxSelect), 0);
        step();
        HRESETn = 1'b1;
        #2;
        step(); #2;
        check("post_rst_hready", 32'(bus.HREADY), 1);
        check("post_rst_hresp",  32'(bus.HRESP), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
